// File: rtl/knight_pkg.sv
// Shared encodings for the knight-rider sequencer: LED pattern modes and sequencer states.
package knight_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_DOT    = 3'd1,
        MODE_BAR_HI = 3'd2,
        MODE_BAR_LO = 3'd3,
        MODE_TRAIL  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encodings 5-7 behave like MODE_OFF.
    function automatic logic mode_active(input logic [2:0] m);
        return (m >= 3'(MODE_DOT)) && (m <= 3'(MODE_TRAIL));
    endfunction

endpackage

// File: rtl/knight_prescaler.sv
// Step-period divider: emits a one-cycle STEP every max(CDIV,1) enabled cycles.
module knight_prescaler #(
    parameter int CDIV_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic [CDIV_W-1:0] CDIV,
    input  logic              CLR,
    output logic              STEP
);

    logic [CDIV_W-1:0] cnt;
    logic [CDIV_W-1:0] last;

    assign last = (CDIV == '0) ? '0 : CDIV - CDIV_W'(1);
    assign STEP = EN && (cnt == last);

    always_ff @(posedge CLK) begin
        if (RESET || CLR)
            cnt <= '0;
        else if (EN)
            cnt <= STEP ? '0 : cnt + CDIV_W'(1);
    end

endmodule

// File: rtl/knight_seq_core.sv
// Knight-rider LED sequencer: bounce patterns, fading trail, one-shot sweeps, and a
// handshaked config port whose changes land only at sweep boundaries.
module knight_seq_core #(
    parameter  int NUM_LED = 8,
    parameter  int CDIV_W  = 32,
    parameter  int PWM_W   = 4,
    localparam int POS_W   = $clog2(2*NUM_LED-2)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CFG_VALID,
    output logic               CFG_READY,
    input  logic [2:0]         CFG_MODE,
    input  logic [CDIV_W-1:0]  CFG_CDIV,
    input  logic               CFG_ONESHOT,
    output logic [NUM_LED-1:0] LED,
    output logic [POS_W-1:0]   POS,
    output logic               BUSY,
    output logic               DONE
);
    import knight_pkg::*;

    localparam int LAST = 2*NUM_LED-3;

    state_e                         state, state_next;
    logic [2:0]                     mode, pend_mode;
    logic [CDIV_W-1:0]              cdiv, pend_cdiv;
    logic                           oneshot, pend_oneshot, pend_valid;
    logic [POS_W-1:0]               pos, pos_inc;
    logic [NUM_LED-1:0][PWM_W-1:0]  level, level_next;
    logic [PWM_W-1:0]               pwm_cnt;
    logic [NUM_LED-1:0]             led_next;
    logic                           step, wrap, apply, accept, enter_done;
    int                             idx, idx_inc;

    // Fold the 0..2N-3 sweep position onto an LED index (up then back down).
    function automatic int pos_to_idx(input logic [POS_W-1:0] p);
        int v;
        v = int'(p);
        return (v < NUM_LED) ? v : 2*NUM_LED-2-v;
    endfunction

    assign wrap      = step && (int'(pos) == LAST);
    assign pos_inc   = (int'(pos) == LAST) ? '0 : pos + POS_W'(1);
    assign idx       = pos_to_idx(pos);
    assign idx_inc   = pos_to_idx(pos_inc);
    // A pending config only lands while stopped or on a wrap step, so a running sweep never glitches.
    assign apply     = pend_valid && ((state != ST_RUN) || wrap);
    assign accept    = CFG_VALID && !pend_valid;
    assign CFG_READY = !pend_valid;
    assign BUSY      = (state == ST_RUN);
    assign POS       = pos;

    knight_prescaler #(.CDIV_W(CDIV_W)) u_presc (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (state == ST_RUN),
        .CDIV  (cdiv),
        .CLR   (apply),
        .STEP  (step)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        enter_done = 1'b0;
        if (apply) begin
            state_next = mode_active(pend_mode) ? ST_RUN : ST_IDLE;
        end else if ((state == ST_RUN) && wrap && oneshot) begin
            state_next = ST_DONE;
            enter_done = 1'b1;
        end
    end

    always_comb begin
        led_next   = '0;
        level_next = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            level_next[i] = (i == idx_inc) ? {PWM_W{1'b1}} : (level[i] >> 1);
            case (mode)
                MODE_DOT:    led_next[i] = (i == idx);
                MODE_BAR_HI: led_next[i] = (i >= idx);
                MODE_BAR_LO: led_next[i] = (i <= idx);
                MODE_TRAIL:  led_next[i] = (level[i] > pwm_cnt);
                default:     led_next[i] = 1'b0;
            endcase
            if (state != ST_RUN) led_next[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode         <= MODE_OFF;
            cdiv         <= '0;
            oneshot      <= 1'b0;
            pos          <= '0;
            level        <= '0;
            pwm_cnt      <= '0;
            pend_valid   <= 1'b0;
            pend_mode    <= MODE_OFF;
            pend_cdiv    <= '0;
            pend_oneshot <= 1'b0;
            LED          <= '0;
            DONE         <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            LED     <= led_next;
            DONE    <= enter_done;
            if (apply) begin
                mode       <= pend_mode;
                cdiv       <= pend_cdiv;
                oneshot    <= pend_oneshot;
                pos        <= '0;
                level      <= '0;
                pend_valid <= 1'b0;
            end else if (step) begin
                pos   <= pos_inc;
                level <= level_next;
            end
            if (accept) begin
                pend_valid   <= 1'b1;
                pend_mode    <= CFG_MODE;
                pend_cdiv    <= CFG_CDIV;
                pend_oneshot <= CFG_ONESHOT;
            end
        end
    end

endmodule

// File: tb/tb_knight_seq_core.sv
// Bench for knight_seq_core: a cycle model of a 4-LED instance compared every cycle,
// directed literal checks on both instances, and an 8-LED instance for one-shot sweeps.
module tb_knight_seq_core;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 0;

    // instance A: 4 LEDs, 2-bit PWM
    logic       a_valid, a_ready, a_os, a_busy, a_done;
    logic [2:0] a_mode;
    logic [7:0] a_cdiv;
    logic [3:0] a_led;
    logic [2:0] a_pos;
    // instance B: 8 LEDs
    logic       b_valid, b_ready, b_os, b_busy, b_done;
    logic [2:0] b_mode;
    logic [7:0] b_cdiv;
    logic [7:0] b_led;
    logic [3:0] b_pos;

    always #5 clk = ~clk;

    knight_seq_core #(.NUM_LED(4), .CDIV_W(8), .PWM_W(2)) dut_a (
        .CLK(clk), .RESET(rst), .CFG_VALID(a_valid), .CFG_READY(a_ready), .CFG_MODE(a_mode),
        .CFG_CDIV(a_cdiv), .CFG_ONESHOT(a_os), .LED(a_led), .POS(a_pos), .BUSY(a_busy), .DONE(a_done));

    knight_seq_core #(.NUM_LED(8), .CDIV_W(8), .PWM_W(4)) dut_b (
        .CLK(clk), .RESET(rst), .CFG_VALID(b_valid), .CFG_READY(b_ready), .CFG_MODE(b_mode),
        .CFG_CDIV(b_cdiv), .CFG_ONESHOT(b_os), .LED(b_led), .POS(b_pos), .BUSY(b_busy), .DONE(b_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance A ----------------
    int         m_st;          // 0 idle, 1 run, 2 done
    int         m_mode, m_p, m_os, m_pos, m_ph, m_pwm;
    int         m_lv[4];
    bit         m_pend;
    int         pm_mode, pm_cdiv, pm_os;
    logic [3:0] e_led;
    bit         e_done;

    initial forever begin : model
        int         idx, npos, nidx;
        bit         step, wrap, apply, pend0;
        logic [3:0] nled;
        @(posedge clk);
        if (rst) begin
            m_st = 0; m_mode = 0; m_p = 1; m_os = 0; m_pos = 0; m_ph = 0; m_pwm = 0;
            foreach (m_lv[i]) m_lv[i] = 0;
            m_pend = 0; e_led = 4'h0; e_done = 0;
        end else begin
            idx  = (m_pos < 4) ? m_pos : 6 - m_pos;
            nled = 4'h0;
            if (m_st == 1) begin
                case (m_mode)
                    1: nled = 4'(1 << idx);
                    2: nled = 4'(15 & ~((1 << idx) - 1));
                    3: nled = 4'((2 << idx) - 1);
                    4: for (int i = 0; i < 4; i++) nled[i] = (m_lv[i] > m_pwm);
                    default: nled = 4'h0;
                endcase
            end
            step   = (m_st == 1) && (m_ph == m_p - 1);
            wrap   = step && (m_pos == 5);
            pend0  = m_pend;
            apply  = m_pend && (m_st != 1 || wrap);
            e_done = 0;
            if (apply) begin
                m_mode = pm_mode; m_p = (pm_cdiv == 0) ? 1 : pm_cdiv; m_os = pm_os;
                m_pos = 0; m_ph = 0;
                foreach (m_lv[i]) m_lv[i] = 0;
                m_st = (pm_mode >= 1 && pm_mode <= 4) ? 1 : 0;
                m_pend = 0;
            end else if (m_st == 1) begin
                if (step) begin
                    m_ph = 0;
                    npos = (m_pos + 1) % 6;
                    nidx = (npos < 4) ? npos : 6 - npos;
                    foreach (m_lv[i]) m_lv[i] = (i == nidx) ? 3 : m_lv[i] / 2;
                    m_pos = npos;
                    if (wrap && m_os != 0) begin m_st = 2; e_done = 1; end
                end else begin
                    m_ph++;
                end
            end
            if (a_valid && !pend0) begin
                m_pend = 1; pm_mode = int'(a_mode); pm_cdiv = int'(a_cdiv); pm_os = int'(a_os);
            end
            m_pwm = (m_pwm + 1) % 4;
            e_led = nled;
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (chk_en) begin
            chk("m_led",   a_led,   e_led);
            chk("m_pos",   a_pos,   m_pos);
            chk("m_busy",  a_busy,  m_st == 1);
            chk("m_done",  a_done,  e_done);
            chk("m_ready", a_ready, !m_pend);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cfg_a(input int mode, input int cdiv, input int os);
        a_valid = 1; a_mode = 3'(mode); a_cdiv = 8'(cdiv); a_os = 1'(os);
        @(negedge clk);
        a_valid = 0;
    endtask

    task automatic go_idle();
        int n = 0;
        cfg_a(0, 1, 0);
        while (!(a_busy == 1'b0 && a_ready == 1'b1) && n < 400) begin @(negedge clk); n++; end
        chk("idle_reached", n < 400, 1);
        @(negedge clk);
    endtask

    task automatic wait_led(input logic [3:0] v, input string nm);
        int n = 0;
        while (a_led !== v && n < 400) begin @(negedge clk); n++; end
        chk(nm, a_led, v);
    endtask

    task automatic wait_pos(input int p, input string nm);
        int n = 0;
        while (int'(a_pos) != p && n < 400) begin @(negedge clk); n++; end
        chk(nm, a_pos, p);
    endtask

    logic [3:0] seq_dot[14] = '{4'h1,4'h1,4'h2,4'h2,4'h4,4'h4,4'h8,4'h8,4'h4,4'h4,4'h2,4'h2,4'h1,4'h1};
    logic [3:0] seq_hi[8]   = '{4'hF,4'hE,4'hC,4'h8,4'hC,4'hE,4'hF,4'hE};
    logic [3:0] seq_lo[8]   = '{4'h1,4'h3,4'h7,4'hF,4'h7,4'h3,4'h1,4'h3};
    logic [3:0] seq_sw[4]   = '{4'h1,4'h1,4'h3,4'h3};

    initial begin
        int n, busy_cnt, done_cnt;
        int c[4];
        rst = 1;
        a_valid = 0; a_mode = 0; a_cdiv = 0; a_os = 0;
        b_valid = 0; b_mode = 0; b_cdiv = 0; b_os = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_led_a", a_led, 0);   chk("rst_pos_a", a_pos, 0);
        chk("rst_busy_a", a_busy, 0); chk("rst_done_a", a_done, 0);
        chk("rst_ready_a", a_ready, 1);
        chk("rst_led_b", b_led, 0);   chk("rst_ready_b", b_ready, 1);
        rst = 0;
        @(negedge clk);

        // dot mode, each LED held for two cycles
        go_idle();
        cfg_a(1, 2, 0);
        wait_led(4'h1, "dot_start");
        for (int k = 0; k < 14; k++) begin chk($sformatf("dot_seq%0d", k), a_led, seq_dot[k]); @(negedge clk); end

        // bar-high / bar-low stepping every cycle; CDIV=0 behaves as 1
        go_idle();
        cfg_a(2, 1, 0);
        wait_led(4'hF, "hi_start");
        for (int k = 0; k < 8; k++) begin chk($sformatf("hi_seq%0d", k), a_led, seq_hi[k]); @(negedge clk); end
        go_idle();
        cfg_a(3, 1, 0);
        wait_led(4'h1, "lo_start");
        for (int k = 0; k < 8; k++) begin chk($sformatf("lo_seq%0d", k), a_led, seq_lo[k]); @(negedge clk); end
        go_idle();
        cfg_a(2, 0, 0);
        wait_led(4'hF, "hi0_start");
        for (int k = 0; k < 8; k++) begin chk($sformatf("hi0_seq%0d", k), a_led, seq_hi[k]); @(negedge clk); end

        // switch dot -> bar-low mid-sweep; change lands at the wrap
        go_idle();
        cfg_a(1, 2, 0);
        wait_pos(2, "sw_pos2");
        a_valid = 1; a_mode = 3'd3; a_cdiv = 8'd2; a_os = 0;
        @(negedge clk);
        chk("sw_ready_drop", a_ready, 0);
        a_mode = 3'd2;
        n = 0;
        while (a_ready == 1'b0 && n < 100) begin @(negedge clk); n++; end
        a_valid = 0;
        chk("sw_ready_back", a_ready, 1);
        chk("sw_pos_wrap", a_pos, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin chk($sformatf("sw_seq%0d", k), a_led, seq_sw[k]); @(negedge clk); end

        // fading trail: after two steps level[2]=3, level[1]=1
        go_idle();
        cfg_a(4, 8, 0);
        wait_pos(2, "tr_pos2");
        @(negedge clk);
        foreach (c[i]) c[i] = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) c[i] += int'(a_led[i]);
            @(negedge clk);
        end
        chk("tr_duty0", c[0], 0); chk("tr_duty1", c[1], 1);
        chk("tr_duty2", c[2], 3); chk("tr_duty3", c[3], 0);

        // one-shot sweep on the 8-LED instance: 14 steps of 3 cycles
        b_valid = 1; b_mode = 3'd1; b_cdiv = 8'd3; b_os = 1;
        @(negedge clk);
        b_valid = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            busy_cnt += int'(b_busy);
            done_cnt += int'(b_done);
            @(negedge clk);
        end
        chk("os_busy_cycles", busy_cnt, 42);
        chk("os_done_pulses", done_cnt, 1);
        chk("os_led_off", b_led, 0);
        chk("os_busy_off", b_busy, 0);
        chk("os_pos0", b_pos, 0);

        // reset with a config pending
        go_idle();
        cfg_a(1, 2, 0);
        wait_pos(3, "rs_pos3");
        cfg_a(2, 1, 0);
        chk("rs_pending", a_ready, 0);
        rst = 1;
        @(negedge clk);
        chk("rs_led", a_led, 0);    chk("rs_pos", a_pos, 0);
        chk("rs_busy", a_busy, 0);  chk("rs_ready", a_ready, 1);
        rst = 0;
        repeat (30) @(negedge clk);
        chk("rs_no_apply_busy", a_busy, 0);
        chk("rs_no_apply_led", a_led, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
